// File: rtl/ofdm_sync_frame_ctrl.sv
// rtl/ofdm_sync_frame_ctrl.sv - frame controller for the OFDM symbol synchroniser
// Arms the synchroniser, gates samples into it, counts symbols and classifies frame errors.
module ofdm_sync_frame_ctrl #(
  parameter int RESET_CYCLES   = 4,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SYMBOL_TIMEOUT = 512
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cfg_num_symbols,
  input  logic [31:0] asi_in0_data,
  input  logic        asi_in0_valid,
  output logic [31:0] sync_out0_data,
  output logic        sync_out0_valid,
  output logic        sync_reset,
  input  logic        sync_pre_sampling,
  input  logic        sync_valid,
  input  logic        sync_sop,
  input  logic        sync_eop,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_error,
  output logic [1:0]  err_code,
  output logic [7:0]  symbol_count
);

  localparam int TMAX = (SEARCH_TIMEOUT > SYMBOL_TIMEOUT) ? SEARCH_TIMEOUT : SYMBOL_TIMEOUT;
  localparam int TW   = ($clog2(TMAX) > 4) ? $clog2(TMAX) : 4;
  localparam logic [TW-1:0] ARM_LAST    = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] SYMBOL_LAST = TW'(SYMBOL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SEARCH, S_RECEIVE, S_DONE, S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    num_q, num_d;
  logic [7:0]    count_q, count_d;
  logic          in_pkt_q, in_pkt_d;
  logic [1:0]    err_q, err_d;
  logic          abort_rst_q, abort_rst_d;
  logic [31:0]   data_q;
  logic          valid_q;

  logic          sop_v, eop_v, framing_err, gate;
  logic [7:0]    count_inc;

  assign sop_v     = sync_valid && sync_sop;
  assign eop_v     = sync_valid && sync_eop;
  assign count_inc = count_q + 8'd1;
  // A single-beat sop+eop is a complete symbol when no packet is open.
  assign framing_err = (sop_v && in_pkt_q) || (eop_v && !sop_v && !in_pkt_q);

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    num_d       = num_q;
    count_d     = count_q;
    in_pkt_d    = in_pkt_q;
    err_d       = err_q;
    abort_rst_d = 1'b0;
    if (abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      abort_rst_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && cfg_num_symbols != 8'd0) begin
            state_d  = S_ARM;
            timer_d  = '0;
            num_d    = cfg_num_symbols;
            count_d  = 8'd0;
            err_d    = 2'd0;
            in_pkt_d = 1'b0;
          end
        end
        S_ARM: begin
          if (timer_q == ARM_LAST) begin
            state_d = S_SEARCH;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_SEARCH: begin
          if (!sync_pre_sampling) begin
            state_d = S_RECEIVE;
            timer_d = '0;
          end else if (timer_q == SEARCH_LAST) begin
            state_d = S_ERROR;
            err_d   = 2'd1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_RECEIVE: begin
          if (framing_err) begin
            state_d = S_ERROR;
            err_d   = 2'd3;
          end else begin
            if (eop_v) begin
              count_d  = count_inc;
              in_pkt_d = 1'b0;
              if (count_inc == num_q) state_d = S_DONE;
            end else if (sop_v) begin
              in_pkt_d = 1'b1;
            end
            // Any packet boundary feeds the symbol watchdog.
            if (sop_v || eop_v) begin
              timer_d = '0;
            end else if (timer_q == SYMBOL_LAST) begin
              state_d = S_ERROR;
              err_d   = 2'd2;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        S_DONE, S_ERROR: state_d = S_IDLE;
        default:         state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    frame_done  = (state_q == S_DONE);
    frame_error = (state_q == S_ERROR);
    gate        = (state_q == S_SEARCH) || (state_q == S_RECEIVE);
    sync_reset  = reset_reset || (state_q == S_ARM) || (state_q == S_ERROR) || abort_rst_q;
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      timer_q     <= '0;
      num_q       <= 8'd0;
      count_q     <= 8'd0;
      in_pkt_q    <= 1'b0;
      err_q       <= 2'd0;
      abort_rst_q <= 1'b0;
      data_q      <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      num_q       <= num_d;
      count_q     <= count_d;
      in_pkt_q    <= in_pkt_d;
      err_q       <= err_d;
      abort_rst_q <= abort_rst_d;
      data_q      <= asi_in0_data;
      valid_q     <= asi_in0_valid && gate;
    end
  end

  assign sync_out0_data  = data_q;
  assign sync_out0_valid = valid_q;
  assign err_code        = err_q;
  assign symbol_count    = count_q;

endmodule

// File: tb/tb_ofdm_sync_frame_ctrl.sv
// tb/tb_ofdm_sync_frame_ctrl.sv - randomized frame scenarios checked against an event-level model
module tb_ofdm_sync_frame_ctrl;

  localparam int RC    = 4;
  localparam int ST    = 16;
  localparam int SYM_T = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [7:0]  cfg_num_symbols;
  logic [31:0] asi_in0_data;
  logic        asi_in0_valid;
  logic [31:0] sync_out0_data;
  logic        sync_out0_valid;
  logic        sync_reset;
  logic        sync_pre_sampling;
  logic        sync_valid, sync_sop, sync_eop;
  logic        busy, frame_done, frame_error;
  logic [1:0]  err_code;
  logic [7:0]  symbol_count;

  int tests = 0;
  int fails = 0;

  ofdm_sync_frame_ctrl #(
    .RESET_CYCLES(RC), .SEARCH_TIMEOUT(ST), .SYMBOL_TIMEOUT(SYM_T)
  ) dut (
    .clock_clk(clk), .reset_reset(rst), .start(start), .abort(abort),
    .cfg_num_symbols(cfg_num_symbols), .asi_in0_data(asi_in0_data),
    .asi_in0_valid(asi_in0_valid), .sync_out0_data(sync_out0_data),
    .sync_out0_valid(sync_out0_valid), .sync_reset(sync_reset),
    .sync_pre_sampling(sync_pre_sampling), .sync_valid(sync_valid),
    .sync_sop(sync_sop), .sync_eop(sync_eop), .busy(busy),
    .frame_done(frame_done), .frame_error(frame_error),
    .err_code(err_code), .symbol_count(symbol_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; cfg_num_symbols = 8'd0;
    asi_in0_data = 32'd0; asi_in0_valid = 1'b0;
    sync_pre_sampling = 1'b1; sync_valid = 1'b0; sync_sop = 1'b0; sync_eop = 1'b0;
  endtask

  // Between packets: either an invalid beat with noise on the markers or a valid unmarked beat.
  function automatic logic [2:0] idle_beat();
    logic [2:0] b;
    b = 3'($urandom_range(0, 7));
    if (b[2]) b = 3'b100;
    return b;
  endfunction

  // mode: 0 clean, 1 double sop, 2 long silence, 3 stray eop; fsym selects the faulty symbol.
  // Sample index i is taken just after the edge that consumes the inputs of iteration i.
  task automatic run_frame(input int n, input int k, input int mode, input int fsym, input bit do_abort);
    logic [2:0] beats[$];
    int  cntb[$];
    int  ev, code, cnt_end, r0, cnt, quiet, gap, len;
    int  n_rst, n_busy, n_done, n_err, done_at, err_at;
    bit  is_done, open, s, e;
    logic [2:0] b;

    for (int sy = 0; sy < n; sy++) begin
      gap = int'($urandom_range(0, 6));
      len = int'($urandom_range(1, 10));
      if (mode == 2 && sy == fsym) gap = SYM_T + int'($urandom_range(0, 3));
      if (mode == 1 && sy == fsym && len < 3) len = 3;
      if (mode == 3 && sy == fsym) beats.push_back(3'b101);
      for (int g = 0; g < gap; g++) beats.push_back(idle_beat());
      if (len == 1) beats.push_back(3'b111);
      else begin
        beats.push_back(3'b110);
        for (int m = 0; m < len - 2; m++)
          beats.push_back((mode == 1 && sy == fsym && m == 0) ? 3'b110 : idle_beat());
        beats.push_back(3'b101);
      end
    end
    for (int p = 0; p < SYM_T + 2; p++) beats.push_back(3'b100);

    // Outcome from the frame rules applied to the beat list.
    r0 = RC + 1 + k;
    code = 0; is_done = 0; cnt = 0;
    if (k >= ST) begin
      ev = RC + ST;
      code = 1;
    end else begin
      open = 0; quiet = 0; ev = 0;
      for (int j = 0; j < beats.size(); j++) begin
        s = beats[j][2] && beats[j][1];
        e = beats[j][2] && beats[j][0];
        cntb.push_back(cnt);
        ev = r0 + 1 + j;
        if ((s && open) || (e && !s && !open)) begin code = 3; break; end
        if (e) begin
          cnt++; open = 0;
          if (cnt == n) begin is_done = 1; break; end
        end else if (s) open = 1;
        if (s || e) quiet = 0;
        else if (quiet == SYM_T - 1) begin code = 2; break; end
        else quiet++;
      end
    end
    cnt_end = cnt;
    if (do_abort) begin
      ev = int'($urandom_range(1, ev));
      cnt_end = (k >= ST || ev <= r0) ? 0 : cntb[ev - r0 - 1];
      code = 0; is_done = 0;
    end

    n_rst = 0; n_busy = 0; n_done = 0; n_err = 0; done_at = -1; err_at = -1;
    for (int i = 0; i <= ev + 1; i++) begin
      start = (i == 0) ? 1'b1 : (i <= ev && $urandom_range(0, 3) == 0);
      cfg_num_symbols = (i == 0) ? 8'(n) : 8'($urandom_range(0, 255));
      abort = do_abort && (i == ev);
      if (i <= RC) sync_pre_sampling = 1'($urandom_range(0, 1));
      else if (k >= ST || i < r0) sync_pre_sampling = 1'b1;
      else if (i == r0) sync_pre_sampling = 1'b0;
      else sync_pre_sampling = 1'($urandom_range(0, 1));
      if (k < ST && i > r0 && i - r0 - 1 < beats.size()) b = beats[i - r0 - 1];
      else b = 3'($urandom_range(0, 7));
      {sync_valid, sync_sop, sync_eop} = b;
      asi_in0_valid = 1'($urandom_range(0, 1));
      asi_in0_data  = $urandom;
      tick();
      check("gate_valid", 32'(sync_out0_valid), 32'(asi_in0_valid && i >= RC + 1 && i <= ev));
      check("gate_data", sync_out0_data, asi_in0_data);
      if (sync_reset) n_rst++;
      if (busy) n_busy++;
      if (frame_done) begin n_done++; done_at = i; end
      if (frame_error) begin n_err++; err_at = i; end
    end
    idle_inputs();

    check("done_pulses", n_done, 32'(is_done));
    check("error_pulses", n_err, 32'(code != 0));
    if (is_done) check("done_at", done_at, ev);
    if (code != 0) check("error_at", err_at, ev);
    check("err_code", 32'(err_code), code);
    check("symbol_count", 32'(symbol_count), cnt_end);
    check("busy_cycles", n_busy, do_abort ? ev : ev + 1);
    check("sync_reset_cycles", n_rst,
          do_abort ? ((ev < RC ? ev : RC) + 1) : (RC + ((code != 0) ? 1 : 0)));
    check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_sync_reset", 32'(sync_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_sync_reset", 32'(sync_reset), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_pulses", {30'd0, frame_done, frame_error}, 32'd0);
    check("post_rst_err_code", 32'(err_code), 32'd0);
    check("post_rst_count", 32'(symbol_count), 32'd0);
    check("post_rst_valid", 32'(sync_out0_valid), 32'd0);
    check("post_rst_data", sync_out0_data, 32'd0);

    asi_in0_valid = 1'b1; asi_in0_data = 32'h1234ABCD;
    tick();
    check("idle_gate_valid", 32'(sync_out0_valid), 32'd0);
    check("idle_gate_data", sync_out0_data, 32'h1234ABCD);
    asi_in0_valid = 1'b0;

    start = 1'b1; cfg_num_symbols = 8'd0;
    tick();
    start = 1'b0;
    check("zero_cfg_busy", 32'(busy), 32'd0);
    tick();
    check("zero_cfg_busy_later", 32'(busy), 32'd0);

    start = 1'b1; cfg_num_symbols = 8'd1;
    tick();
    start = 1'b0;
    repeat (RC) tick();
    asi_in0_valid = 1'b1; asi_in0_data = 32'h1234ABCD;
    tick();
    check("search_gate_valid", 32'(sync_out0_valid), 32'd1);
    check("search_gate_data", sync_out0_data, 32'h1234ABCD);
    asi_in0_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sync_reset", 32'(sync_reset), 32'd1);
    tick();
    check("abort_sync_reset_end", 32'(sync_reset), 32'd0);

    run_frame(3, 10, 0, 0, 1'b0);
    tick();
    run_frame(2, ST + 5, 0, 0, 1'b0);
    tick();
    run_frame(2, 3, 1, 0, 1'b0);
    tick();
    run_frame(2, 0, 2, 1, 1'b0);
    tick();
    run_frame(3, ST - 1, 0, 0, 1'b1);
    tick();
    for (int f = 0; f < 40; f++) begin
      n = int'($urandom_range(1, 4));
      run_frame(n, int'($urandom_range(0, ST + 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, n - 1)), $urandom_range(0, 4) == 0);
      tick();
    end

    start = 1'b1; cfg_num_symbols = 8'd2;
    tick();
    start = 1'b0;
    repeat (RC + 3) tick();
    asi_in0_valid = 1'b1;
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sync_reset", 32'(sync_reset), 32'd1);
    check("midrst_valid", 32'(sync_out0_valid), 32'd0);
    check("midrst_pulses", {30'd0, frame_done, frame_error}, 32'd0);
    rst = 1'b0; asi_in0_valid = 1'b0;
    tick();
    check("midrst_release", 32'(sync_reset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
